// File: rtl/hub75_bcm_scan.sv
// hub75_bcm_scan: HUB75 two-half-panel scanner with binary-coded modulation.
// Each row is sent as BPC bit-planes. Every plane goes through SHIFT (columns
// are fetched from a 1-cycle-latency pixel source and shifted out), then LATCH,
// then DISPLAY for ON_BASE<<plane cycles.
// Optional feature macro: HUB75_BRIGHTNESS_EN adds an 8-bit global brightness
// input. It gates how much of each DISPLAY window is actually lit.
// All panel-facing outputs are registered. The internal counters describe the
// cycle whose outputs are loaded at the next clock edge, so the outputs trail
// the FSM by one cycle. The reset values of the outputs are therefore clean.
module hub75_bcm_scan #(
   parameter int unsigned WIDTH   = 64,
   parameter int unsigned ROWS    = 32,
   parameter int unsigned BPC     = 4,
   parameter int unsigned ON_BASE = 16,
   localparam int unsigned XW     = $clog2(WIDTH),
   localparam int unsigned AW     = $clog2(ROWS)
) (
   input  logic             clk,
   input  logic             rstn,
`ifdef HUB75_BRIGHTNESS_EN
   input  logic [7:0]       brightness,
`endif
   output logic [XW-1:0]    pix_x,
   output logic [AW-1:0]    pix_y,
   input  logic [3*BPC-1:0] pix_rgb0,
   input  logic [3*BPC-1:0] pix_rgb1,
   output logic             sclk,
   output logic             latch,
   output logic             blank,
   output logic [AW-1:0]    addry,
   output logic [2:0]       rgb0,
   output logic [2:0]       rgb1,
   output logic             frame_start
);

   // Shift-phase cycle counter spans 0 .. 2*WIDTH+1.
   localparam int unsigned KW   = $clog2(2 * WIDTH + 2);
   localparam int unsigned PW   = (BPC > 1) ? $clog2(BPC) : 1;
   // The display counter covers the longest plane (ON_BASE<<(BPC-1)) exactly.
   localparam int unsigned DMAX = ON_BASE << (BPC - 1);
   localparam int unsigned DW   = (DMAX > 1) ? $clog2(DMAX) : 1;
   localparam int unsigned DWP  = DW + 1;

   localparam logic [KW-1:0]  KPIX   = KW'(2 * WIDTH);
   localparam logic [KW-1:0]  KLAST  = KW'(2 * WIDTH + 1);
   localparam logic [KW-1:0]  KTWO   = KW'(2);
   localparam logic [KW-1:0]  KTHREE = KW'(3);
   localparam logic [PW-1:0]  PLAST  = PW'(BPC - 1);
   localparam logic [AW-1:0]  RLAST  = AW'(ROWS - 1);
   localparam logic [DW:0]    ON_W   = DWP'(ON_BASE);

   typedef enum logic [1:0] {
      StShift,
      StLatch,
      StDisplay
   } state_e;

   state_e           state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic [DW-1:0]    disp_q, disp_d;
   logic [PW-1:0]    plane_q, plane_d;
   logic [AW-1:0]    row_q, row_d;

   logic [XW-1:0]    pix_x_q, pix_x_d;
   logic [AW-1:0]    pix_y_q, pix_y_d;
   logic             sclk_q, sclk_d;
   logic             latch_q, latch_d;
   logic             blank_q, blank_d;
   logic [AW-1:0]    addry_q, addry_d;
   logic [2:0]       rgb0_q, rgb0_d;
   logic [2:0]       rgb1_q, rgb1_d;
   logic             fs_q, fs_d;

   // Split the channel fields so the current plane bit can be picked per colour.
   logic [BPC-1:0]   r0, g0, b0, r1, g1, b1;
   assign r0 = pix_rgb0[BPC-1:0];
   assign g0 = pix_rgb0[2*BPC-1:BPC];
   assign b0 = pix_rgb0[3*BPC-1:2*BPC];
   assign r1 = pix_rgb1[BPC-1:0];
   assign g1 = pix_rgb1[2*BPC-1:BPC];
   assign b1 = pix_rgb1[3*BPC-1:2*BPC];

   // On-time of the current plane and end-of-plane detect.
   logic [DW:0]      on_len;
   logic             disp_last;
   logic             lit;
   assign on_len    = ON_W << plane_q;
   assign disp_last = ({1'b0, disp_q} == (on_len - 1'b1));

`ifdef HUB75_BRIGHTNESS_EN
   logic [7:0]       bright_q, bright_d;
   logic [DW+8:0]    lit_prod;
   // The lit part of the window is (on_len * brightness) >> 8 cycles, counted
   // from the start of DISPLAY.
   assign lit_prod = {8'b0, on_len} * {{DWP{1'b0}}, bright_q};
   assign lit      = ({1'b0, disp_q} < lit_prod[DW+8:8]);
`else
   assign lit      = 1'b1;
`endif

   // Next-state and next-output decode for scan FSM and counters.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      disp_d  = disp_q;
      plane_d = plane_q;
      row_d   = row_q;
      pix_x_d = pix_x_q;
      pix_y_d = pix_y_q;
      sclk_d  = 1'b0;
      latch_d = 1'b0;
      blank_d = 1'b1;
      addry_d = addry_q;
      rgb0_d  = rgb0_q;
      rgb1_d  = rgb1_q;
      fs_d    = 1'b0;
`ifdef HUB75_BRIGHTNESS_EN
      bright_d = bright_q;
`endif
      unique case (state_q)
         StShift: begin
            fs_d = (k_q == '0) && (row_q == '0) && (plane_q == '0);
            // Even k below 2*WIDTH requests column k/2.
            if (!k_q[0] && (k_q < KPIX)) begin
               pix_x_d = k_q[XW:1];
               pix_y_d = row_q;
            end
            // Even k from 2 on: the source answers the request from k-2.
            if (!k_q[0] && (k_q >= KTWO)) begin
               rgb0_d = {b0[plane_q], g0[plane_q], r0[plane_q]};
               rgb1_d = {b1[plane_q], g1[plane_q], r1[plane_q]};
            end
            // The rising shift edge falls in the middle of each data slot.
            sclk_d = k_q[0] && (k_q >= KTHREE);
            if (k_q == KLAST) begin
               k_d     = '0;
               state_d = StLatch;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         StLatch: begin
            latch_d = 1'b1;
            addry_d = row_q;
`ifdef HUB75_BRIGHTNESS_EN
            bright_d = brightness;
`endif
            disp_d  = '0;
            state_d = StDisplay;
         end
         StDisplay: begin
            blank_d = !lit;
            if (disp_last) begin
               disp_d  = '0;
               state_d = StShift;
               if (plane_q == PLAST) begin
                  plane_d = '0;
                  row_d   = (row_q == RLAST) ? '0 : row_q + 1'b1;
               end else begin
                  plane_d = plane_q + 1'b1;
               end
            end else begin
               disp_d = disp_q + 1'b1;
            end
         end
         default: begin
            state_d = StShift;
            k_d     = '0;
         end
      endcase
   end

   // State and output registers; reset darkens the panel immediately.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= StShift;
         k_q      <= '0;
         disp_q   <= '0;
         plane_q  <= '0;
         row_q    <= '0;
         pix_x_q  <= '0;
         pix_y_q  <= '0;
         sclk_q   <= 1'b0;
         latch_q  <= 1'b0;
         blank_q  <= 1'b1;
         addry_q  <= '0;
         rgb0_q   <= '0;
         rgb1_q   <= '0;
         fs_q     <= 1'b0;
`ifdef HUB75_BRIGHTNESS_EN
         bright_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         disp_q   <= disp_d;
         plane_q  <= plane_d;
         row_q    <= row_d;
         pix_x_q  <= pix_x_d;
         pix_y_q  <= pix_y_d;
         sclk_q   <= sclk_d;
         latch_q  <= latch_d;
         blank_q  <= blank_d;
         addry_q  <= addry_d;
         rgb0_q   <= rgb0_d;
         rgb1_q   <= rgb1_d;
         fs_q     <= fs_d;
`ifdef HUB75_BRIGHTNESS_EN
         bright_q <= bright_d;
`endif
      end
   end

   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign sclk        = sclk_q;
   assign latch       = latch_q;
   assign blank       = blank_q;
   assign addry       = addry_q;
   assign rgb0        = rgb0_q;
   assign rgb1        = rgb1_q;
   assign frame_start = fs_q;

endmodule
